// File: rtl/btb_update.sv
// btb_update -- write side of the branch target buffer.
//
// Takes resolved control transfers from EX and decides whether the BTB entry
// must be allocated, retargeted or invalidated. Resulting write packets are
// queued in a small FIFO and drained one per cycle onto the BTB write port.
// The block also owns the full-table clear sweep, which runs after reset and
// after a flush request. Pending updates are drained before the sweep starts.
//
// Optional feature macro: BTB_HYST_EN
//   When defined, a 2-bit confidence counter per BTB index adds hysteresis.
//   A not-taken branch that hit only invalidates its entry once confidence
//   has decayed to 1 or 0. When undefined, every not-taken hit invalidates
//   its entry, and no counters are built.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   ex_valid / ex_ready   EX update handshake (ex_ready is combinational)
//   ex_pc, ex_taken       branch PC and its resolved direction
//   ex_target             resolved target (meaningful when taken)
//   ex_btb_hit/pred_pc    fetch-time BTB lookup result carried down the pipe
//   flush_req             one-cycle request for a full BTB invalidate
//   flush_busy            drain or sweep in progress (registered)
//   btb_we/waddr/wd       BTB write port, wd = {valid, tag, target} (registered)
module btb_update #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 17,
  parameter int IDX_W = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ex_valid,
  output logic                          ex_ready,
  input  logic [PC_W-1:0]               ex_pc,
  input  logic                          ex_taken,
  input  logic [PC_W-1:0]               ex_target,
  input  logic                          ex_btb_hit,
  input  logic [PC_W-1:0]               ex_pred_pc,
  input  logic                          flush_req,
  output logic                          flush_busy,
  output logic                          btb_we,
  output logic [IDX_W-1:0]              btb_waddr,
  output logic [PC_W+(PC_W-IDX_W-2):0]  btb_wd
);

  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam int WD_W  = 1 + TAG_W + PC_W;
  localparam int ENT_W = IDX_W + WD_W;
  localparam int NENT  = 1 << IDX_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SWEEP
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     sweep_idx_q, sweep_idx_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 btb_we_q, btb_we_d;
  logic [IDX_W-1:0]     btb_waddr_q, btb_waddr_d;
  logic [WD_W-1:0]      btb_wd_q, btb_wd_d;
  logic                 flush_busy_q, flush_busy_d;

  // Each FIFO entry carries the write index alongside the BTB data word.
  logic [ENT_W-1:0]     fifo_mem [DEPTH];
  logic [ENT_W-1:0]     fifo_head;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 accept;
  logic                 push_en;
  logic                 pop_en;
  logic [ENT_W-1:0]     push_data;
  logic [IDX_W-1:0]     ex_idx;
  logic [TAG_W-1:0]     ex_tag;
  logic                 unused_pc_lsb;

  assign ex_idx        = ex_pc[IDX_W+1:2];
  assign ex_tag        = ex_pc[PC_W-1:IDX_W+2];
  // Instruction-aligned PCs: the two low bits never reach the BTB.
  assign unused_pc_lsb = ^ex_pc[1:0];

  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign fifo_head  = fifo_mem[rd_ptr_q];

  // A flush request takes priority over an update presented in the same cycle.
  assign ex_ready = (state_q == ST_IDLE) && !fifo_full && !flush_req;
  assign accept   = ex_valid && ex_ready;

  // The sweep owns the write port, so the queue is only drained outside it.
  assign pop_en   = (state_q != ST_SWEEP) && !fifo_empty;

`ifdef BTB_HYST_EN
  logic [1:0] ctr_q [NENT];
  logic [1:0] ctr_d [NENT];
`endif

  // Update decision: what (if anything) to write for an accepted update.
  always_comb begin
    push_en   = 1'b0;
    push_data = {ex_idx, 1'b1, ex_tag, ex_target};
`ifdef BTB_HYST_EN
    ctr_d     = ctr_q;
`endif
    if (accept) begin
      if (ex_taken) begin
        if (!ex_btb_hit || (ex_pred_pc != ex_target)) begin
          // Missing or wrong target: allocate/retarget, confidence restarts.
          push_en = 1'b1;
`ifdef BTB_HYST_EN
          ctr_d[ex_idx] = 2'd1;
`endif
        end else begin
`ifdef BTB_HYST_EN
          if (ctr_q[ex_idx] != 2'd3) begin
            ctr_d[ex_idx] = ctr_q[ex_idx] + 2'd1;
          end
`endif
        end
      end else if (ex_btb_hit) begin
`ifdef BTB_HYST_EN
        if (ctr_q[ex_idx] <= 2'd1) begin
          push_en       = 1'b1;
          push_data     = {ex_idx, 1'b0, ex_tag, {PC_W{1'b0}}};
          ctr_d[ex_idx] = 2'd0;
        end else begin
          ctr_d[ex_idx] = ctr_q[ex_idx] - 2'd1;
        end
`else
        push_en   = 1'b1;
        push_data = {ex_idx, 1'b0, ex_tag, {PC_W{1'b0}}};
`endif
      end
    end
  end

  // FIFO bookkeeping; pointers wrap naturally because DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_en && !pop_en) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_en && pop_en) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Control FSM and write-port output selection.
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    btb_we_d    = 1'b0;
    btb_waddr_d = btb_waddr_q;
    btb_wd_d    = btb_wd_q;

    case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_d     = ST_SWEEP;
          sweep_idx_d = '0;
        end
      end
      ST_SWEEP: begin
        btb_we_d    = 1'b1;
        btb_waddr_d = sweep_idx_q;
        btb_wd_d    = '0;
        sweep_idx_d = sweep_idx_q + IDX_W'(1);
        if (sweep_idx_q == IDX_W'(NENT - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_SWEEP;
      end
    endcase

    if (pop_en) begin
      btb_we_d    = 1'b1;
      btb_waddr_d = fifo_head[ENT_W-1:WD_W];
      btb_wd_d    = fifo_head[WD_W-1:0];
    end
  end

  assign flush_busy_d = (state_d != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SWEEP;
      sweep_idx_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      btb_we_q     <= 1'b0;
      btb_waddr_q  <= '0;
      btb_wd_q     <= '0;
      flush_busy_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      sweep_idx_q  <= sweep_idx_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      btb_we_q     <= btb_we_d;
      btb_waddr_q  <= btb_waddr_d;
      btb_wd_q     <= btb_wd_d;
      flush_busy_q <= flush_busy_d;
    end
  end

  // Queue storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_en) begin
      fifo_mem[wr_ptr_q] <= push_data;
    end
  end

`ifdef BTB_HYST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NENT; i++) begin
        ctr_q[i] <= 2'd0;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end
`endif

  assign btb_we     = btb_we_q;
  assign btb_waddr  = btb_waddr_q;
  assign btb_wd     = btb_wd_q;
  assign flush_busy = flush_busy_q;

endmodule
